// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS inter-stage pipeline registers.
//
// Contents:
//   CTRL_MEM_TO_REG, CTRL_REG_WRITE : bit positions inside the control field
//   DATA_W_MEM_WB, RD_W             : default payload / destination widths
//   pipe_entry_t                    : packed {ctrl, data, rd} entry at default widths
package pipe_pkg;

  localparam int unsigned CTRL_MEM_TO_REG = 0;
  localparam int unsigned CTRL_REG_WRITE  = 1;

  localparam int unsigned CTRL_W_DEFAULT = 2;
  localparam int unsigned DATA_W_MEM_WB  = 32;
  localparam int unsigned RD_W           = 3;

  typedef struct packed {
    logic [CTRL_W_DEFAULT-1:0] ctrl;
    logic [DATA_W_MEM_WB-1:0]  data;
    logic [RD_W-1:0]           rd;
  } pipe_entry_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: a valid bit plus a payload register.
//
// Parameters:
//   W          : payload width
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset (valid and payload to 0)
//   i_load     : capture i_payload and mark the entry valid (wins over i_clr)
//   i_clr      : mark the entry invalid; the payload is kept
//   i_payload  : data to capture
//   o_valid    : entry holds live data
//   o_payload  : stored payload
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic         i_clr,
  input  logic [W-1:0] i_payload,
  output logic         o_valid,
  output logic [W-1:0] o_payload
);

  logic         r_valid;
  logic [W-1:0] r_payload;

  // Load beats clear so that drain-and-refill in one edge keeps the entry valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid   <= 1'b0;
      r_payload <= '0;
    end else if (i_load) begin
      r_valid   <= 1'b1;
      r_payload <= i_payload;
    end else if (i_clr) begin
      r_valid   <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_payload = r_payload;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, synchronous
// flush, bubble zeroing of control bits and a saturating back-pressure counter.
//
// Build option: define PIPE_SKID_EN to add a skid entry behind the main entry,
// which makes in_ready purely registered. Without it a single entry is used and
// in_ready depends combinationally on out_ready.
//
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   flush                 : drop every held entry and the entry offered this cycle
//   in_valid/in_ready     : upstream handshake
//   in_ctrl/in_data/in_rd : upstream payload
//   out_valid/out_ready   : downstream handshake
//   out_ctrl              : control bits, zero whenever out_valid is 0
//   out_data/out_rd       : payload, held while invalid
//   stall_cnt             : saturating count of out_valid && !out_ready cycles
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned DATA_W = pipe_pkg::DATA_W_MEM_WB,
  parameter int unsigned RD_W   = pipe_pkg::RD_W,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  localparam int unsigned PayW = CTRL_W + DATA_W + RD_W;

  logic [PayW-1:0]   w_in_pay;
  logic [PayW-1:0]   w_main_pay;
  logic [PayW-1:0]   w_main_d;
  logic              w_main_v;
  logic              w_main_load;
  logic              w_main_clr;
  logic              w_accept;
  logic              w_drain;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_in_pay = {in_ctrl, in_data, in_rd};
  assign w_drain  = w_main_v && out_ready;
  assign w_accept = in_valid && in_ready;

`ifdef PIPE_SKID_EN
  logic            w_skid_v;
  logic [PayW-1:0] w_skid_pay;
  logic            w_skid_load;
  logic            w_skid_clr;

  assign in_ready = !w_skid_v;

  // The skid entry is only ever occupied while main is full, so when it is
  // valid it always has priority for the main slot and in_ready is low.
  always_comb begin
    w_main_load = 1'b0;
    w_main_d    = w_in_pay;
    w_skid_load = 1'b0;
    if (!flush) begin
      if (w_skid_v) begin
        w_main_load = w_drain;
        w_main_d    = w_skid_pay;
      end else if (w_accept) begin
        if (!w_main_v || w_drain) begin
          w_main_load = 1'b1;
        end else begin
          w_skid_load = 1'b1;
        end
      end
    end
  end

  assign w_main_clr = flush || w_drain;
  assign w_skid_clr = flush || (w_skid_v && w_drain);

  pipe_entry_reg #(
    .W (PayW)
  ) u_skid (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_load    (w_skid_load),
    .i_clr     (w_skid_clr),
    .i_payload (w_in_pay),
    .o_valid   (w_skid_v),
    .o_payload (w_skid_pay)
  );
`else
  assign in_ready = out_ready || !w_main_v;

  always_comb begin
    w_main_d    = w_in_pay;
    w_main_load = w_accept && !flush;
  end

  assign w_main_clr = flush || w_drain;
`endif

  pipe_entry_reg #(
    .W (PayW)
  ) u_main (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_load    (w_main_load),
    .i_clr     (w_main_clr),
    .i_payload (w_main_d),
    .o_valid   (w_main_v),
    .o_payload (w_main_pay)
  );

  assign {w_main_ctrl, out_data, out_rd} = w_main_pay;
  assign out_valid = w_main_v;
  // A bubble must never carry reg_write / mem_to_reg downstream.
  assign out_ctrl  = w_main_v ? w_main_ctrl : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !out_ready && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  pipe_entry_t in_e;

  logic        in_ready,  out_valid;
  logic [1:0]  out_ctrl;
  logic [31:0] out_data;
  logic [2:0]  out_rd;
  logic [15:0] stall_cnt;

  logic        in_ready2, out_valid2;
  logic [1:0]  out_ctrl2;
  logic [31:0] out_data2;
  logic [2:0]  out_rd2;
  logic [3:0]  stall_cnt2;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(
    .CTRL_W (2),
    .DATA_W (32),
    .RD_W   (3),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_e.ctrl),
    .in_data   (in_e.data),
    .in_rd     (in_e.rd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(
    .CTRL_W (2),
    .DATA_W (32),
    .RD_W   (3),
    .CNT_W  (4)
  ) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_ctrl   (in_e.ctrl),
    .in_data   (in_e.data),
    .in_rd     (in_e.rd),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl2),
    .out_data  (out_data2),
    .out_rd    (out_rd2),
    .stall_cnt (stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [1:0] c, input logic [31:0] d,
                       input logic [2:0] r);
    in_valid  = v;
    in_e.ctrl = c;
    in_e.data = d;
    in_e.rd   = r;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [1:0] c,
                           input logic [31:0] d, input logic [2:0] r);
    check_eq({tag, ".valid"}, 64'(out_valid), 64'(v));
    check_eq({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
    check_eq({tag, ".data"},  64'(out_data),  64'(d));
    check_eq({tag, ".rd"},    64'(out_rd),    64'(r));
  endtask

  logic [1:0] rw_ctrl;
  logic [1:0] m2r_ctrl;

  initial begin
    rw_ctrl  = '0;
    m2r_ctrl = '0;
    rw_ctrl[CTRL_REG_WRITE]  = 1'b1;
    m2r_ctrl[CTRL_MEM_TO_REG] = 1'b1;

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    offer(1'b0, 2'b00, 32'h0, 3'd0);
    #12;
    check_out("reset", 1'b0, 2'b00, 32'h0, 3'd0);
    check_eq("reset.stall", 64'(stall_cnt), 64'd0);
    check_eq("reset.in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    // 1. streaming
    out_ready = 1'b1;
    offer(1'b1, rw_ctrl, 32'h0001_AAAA, 3'd1);
    step();
    check_out("stream0", 1'b1, rw_ctrl, 32'h0001_AAAA, 3'd1);
    offer(1'b1, m2r_ctrl, 32'h0002_BBBB, 3'd2);
    step();
    check_out("stream1", 1'b1, m2r_ctrl, 32'h0002_BBBB, 3'd2);
    offer(1'b1, 2'b11, 32'h0003_CCCC, 3'd3);
    step();
    check_out("stream2", 1'b1, 2'b11, 32'h0003_CCCC, 3'd3);
    offer(1'b0, 2'b00, 32'h0, 3'd0);
    step();
    check_out("stream_idle", 1'b0, 2'b00, 32'h0003_CCCC, 3'd3);
    check_eq("stream.stall", 64'(stall_cnt), 64'd0);

    // 2. back-pressure
    out_ready = 1'b0;
    offer(1'b1, 2'b10, 32'h11, 3'd4);
    step();
    check_out("bp_first", 1'b1, 2'b10, 32'h11, 3'd4);
    offer(1'b1, 2'b01, 32'h22, 3'd5);
    #1;
`ifdef PIPE_SKID_EN
    check_eq("bp.in_ready_second", 64'(in_ready), 64'd1);
`else
    check_eq("bp.in_ready_second", 64'(in_ready), 64'd0);
`endif
    step();
    check_eq("bp.in_ready_full", 64'(in_ready), 64'd0);
`ifdef PIPE_SKID_EN
    offer(1'b0, 2'b00, 32'h0, 3'd0);
`endif
    for (int i = 0; i < 3; i++) step();
    check_out("bp_hold", 1'b1, 2'b10, 32'h11, 3'd4);
    check_eq("bp.stall", 64'(stall_cnt), 64'd4);
    out_ready = 1'b1;
    step();
`ifndef PIPE_SKID_EN
    offer(1'b0, 2'b00, 32'h0, 3'd0);
`endif
    check_out("bp_drain1", 1'b1, 2'b01, 32'h22, 3'd5);
    step();
    check_out("bp_drain_empty", 1'b0, 2'b00, 32'h22, 3'd5);
    check_eq("bp.stall_after", 64'(stall_cnt), 64'd4);

    // 3. bubble
    offer(1'b0, 2'b11, 32'hDEAD, 3'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("bubble.valid", 64'(out_valid), 64'd0);
      check_eq("bubble.ctrl", 64'(out_ctrl), 64'd0);
    end

    // 4. flush
    out_ready = 1'b0;
    offer(1'b1, 2'b01, 32'h33, 3'd1);
    step();
`ifdef PIPE_SKID_EN
    offer(1'b1, 2'b10, 32'h44, 3'd2);
    step();
    check_eq("flush.skid_full", 64'(in_ready), 64'd0);
`endif
    check_out("flush_pre", 1'b1, 2'b01, 32'h33, 3'd1);
    out_ready = 1'b1;
    flush = 1'b1;
    offer(1'b1, 2'b11, 32'h55, 3'd6);
    step();
    flush = 1'b0;
    offer(1'b0, 2'b00, 32'h0, 3'd0);
    check_out("flush_post", 1'b0, 2'b00, 32'h33, 3'd1);
    check_eq("flush.in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("flush.never_out", 64'(out_valid), 64'd0);
    end

    // 5. asynchronous reset mid-cycle
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    out_ready = 1'b0;
    offer(1'b1, 2'b11, 32'h66, 3'd6);
    step();
    offer(1'b0, 2'b00, 32'h0, 3'd0);
    for (int i = 0; i < 7; i++) step();
    check_out("arst_pre", 1'b1, 2'b11, 32'h66, 3'd6);
    check_eq("arst_pre.stall", 64'(stall_cnt), 64'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("arst", 1'b0, 2'b00, 32'h0, 3'd0);
    check_eq("arst.stall", 64'(stall_cnt), 64'd0);
    check_eq("arst.in_ready", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;

    // 6. saturation (dut_sat has CNT_W=4)
    out_ready = 1'b0;
    offer(1'b1, 2'b01, 32'h77, 3'd2);
    step();
    offer(1'b0, 2'b00, 32'h0, 3'd0);
    for (int i = 0; i < 15; i++) step();
    check_eq("sat.cnt15", 64'(stall_cnt2), 64'd15);
    check_eq("sat.wide15", 64'(stall_cnt), 64'd15);
    for (int i = 0; i < 5; i++) step();
    check_eq("sat.hold", 64'(stall_cnt2), 64'd15);
    check_eq("sat.wide20", 64'(stall_cnt), 64'd20);
    check_eq("sat.valid", 64'(out_valid2), 64'd1);
    check_eq("sat.ctrl", 64'(out_ctrl2), 64'd1);
    check_eq("sat.data", 64'(out_data2), 64'h77);
    check_eq("sat.rd", 64'(out_rd2), 64'd2);
`ifdef PIPE_SKID_EN
    check_eq("sat.in_ready", 64'(in_ready2), 64'd1);
`else
    check_eq("sat.in_ready", 64'(in_ready2), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the 16-bit MIPS pipeline. It generalises the fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches into one block with configurable control, data and destination widths. It adds a valid/ready handshake, a synchronous flush, and bubble zeroing of control bits. An optional skid buffer breaks the combinational ready path between stages.

## Interface
Parameters:
- `CTRL_W`, default 2: control-signal bits, for example `mem_to_reg` and `reg_write`.
- `DATA_W`, default 32: concatenated data payload, for example ALU result plus memory data.
- `RD_W`, default 3: destination-register index width.
- `CNT_W`, default 16: stall-counter width.

Ports:
- `clk`  in  1: pipeline clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `flush`  in  1: synchronous kill of all held entries.
- `in_valid`  in  1: upstream stage presents an entry.
- `in_ready`  out  1: this stage accepts the entry this cycle.
- `in_ctrl`  in  CTRL_W: upstream control bits.
- `in_data`  in  DATA_W: upstream data payload.
- `in_rd`  in  RD_W: upstream destination register.
- `out_valid`  out  1: entry available to the downstream stage.
- `out_ready`  in  1: downstream stage consumes the entry this cycle.
- `out_ctrl`  out  CTRL_W: control bits; forced to 0 whenever `out_valid` is 0.
- `out_data`  out  DATA_W: data payload.
- `out_rd`  out  RD_W: destination register.
- `stall_cnt`  out  CNT_W: saturating count of back-pressure cycles.

## Operation
- Transfer-in occurs when `in_valid && in_ready`. Transfer-out occurs when `out_valid && out_ready`.
- Main register (`main_v`, payload) drives the outputs.
- Bubble rule: `out_ctrl = main_v ? ctrl_q : 0`. A bubble can therefore never assert `reg_write` or `mem_to_reg`.
- `out_data` and `out_rd` hold their last value while the stage is invalid. They are not zeroed.
- Flush:
  - When `flush` is 1 at a clock edge, all valid bits clear.
  - The input presented in the same cycle is discarded; flush dominates a simultaneous transfer-in.
  - Payload registers are not cleared.
- Stall counter:
  - Increments on each cycle with `out_valid && !out_ready`.
  - Saturates at 2^CNT_W−1; there is no wrap.
  - Cleared only by reset.
- Reset values: `main_v`=0, skid valid=0, `out_ctrl`=0, `out_data`=0, `out_rd`=0, `stall_cnt`=0. `in_ready` takes its idle value, which is 1 in both build variants.
- Reset asserted mid-operation drops all in-flight entries immediately and asynchronously.

## Timing
- Latency is 1 cycle: an entry accepted at edge N appears on the outputs after edge N.
- Throughput is 1 entry per cycle when `out_ready` is held at 1.
- There is no combinational path from `in_*` to `out_*`.
- Once `out_valid` is 1, `out_valid` and the payload stay stable until the transfer-out occurs or a flush arrives.
- `in_valid` may be asserted before `in_ready` is seen. Upstream must hold its payload until `in_ready` is observed.

## Configuration
The skid buffer is selected by the macro `PIPE_SKID_EN`.

With `PIPE_SKID_EN` defined:
- A second entry register (skid) is added behind the main register.
- `in_ready = !skid_v` is purely registered and has no combinational dependence on `out_ready`.
- If an entry is accepted while the main register is full and not draining, the entry goes into the skid register.
- When the main register drains, the skid entry moves into the main register in the same edge.
- Entry order is preserved.

Without `PIPE_SKID_EN`:
- A single register is used.
- `in_ready = out_ready || !main_v`, which is combinational.
- Accept and drain in the same edge replaces the entry.

## Structure
- Shared package `pipe_pkg`:
  - Named control-bit index constants (`CTRL_MEM_TO_REG`, `CTRL_REG_WRITE`).
  - Default widths: `DATA_W_MEM_WB` = 32, `RD_W` = 3.
  - A packed entry typedef `{ctrl, data, rd}`.
- One sub-module, `pipe_entry_reg`: a valid bit plus payload with load enable and clear, instantiated once for main and once for skid.
- The top level holds the handshake logic and the stall counter.

## Test plan
1. Streaming:
   - Stimulus: reset, then `out_ready`=1 and three entries with `in_data` 0x0001_AAAA, 0x0002_BBBB, 0x0003_CCCC and `in_rd` 1, 2, 3 on consecutive cycles.
   - Required: the same three entries appear one cycle later in order, with `stall_cnt`=0.
2. Back-pressure:
   - Stimulus: hold `out_ready`=0 for 4 cycles with entries 0x11 and 0x22 offered.
   - Required with `PIPE_SKID_EN`: both are accepted and `in_ready` falls after the second.
   - Required without `PIPE_SKID_EN`: only 0x11 is accepted.
   - Required in both builds: `stall_cnt`=4; after `out_ready` returns to 1, the entries drain in order.
3. Bubble:
   - Stimulus: `in_ctrl`=2'b11 presented with `in_valid`=0.
   - Required: `out_valid`=0 and `out_ctrl`=2'b00 every cycle.
4. Flush:
   - Stimulus: main and skid both full, then `flush` plus `in_valid` with `in_ctrl`=2'b11 in the same cycle.
   - Required: next cycle `out_valid`=0, `out_ctrl`=0, `in_ready`=1, and the new entry is never output.
5. Asynchronous reset:
   - Stimulus: drop `rst_n` mid-cycle while `out_valid`=1 and `stall_cnt`=7.
   - Required: before the next edge, `out_valid`=0, `out_ctrl`=0 and `stall_cnt`=0.
6. Saturation:
   - Stimulus: `CNT_W`=4 with `out_ready`=0 for 20 cycles.
   - Required: `stall_cnt` stops at 15.
